seq_mult4_ctrl: RTL and testbench

SEQ_MULT4_CTRL -- requirements
Module: seq_mult4_ctrl

---
 rtl/seq_mult4_ctrl_pkg.sv | 19 +
 rtl/seq_mult4_ctrl_adder4.sv | 24 ++
 rtl/seq_mult4_ctrl.sv | 86 ++++++++
 tb/tb_seq_mult4_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult4_ctrl_pkg.sv
// Shared constants and state encoding for the 4x4 shift-add multiplier controller.
// Imported by the controller and by its adder sub-module.
package seq_mult4_ctrl_pkg;

   localparam int WIDTH = 4;
   localparam int ITER  = 4;
   localparam int CNT_W = 2;
   localparam int PROD_W = 2 * WIDTH;

   // Iteration index at which the final shift lands in the product register.
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_mult4_ctrl_adder4.sv
// 4-bit ripple-carry adder built from per-bit full adders.
// The full carry chain is exposed; its top bit is the adder's carry-out.
module adder4
   import seq_mult4_ctrl_pkg::*;
(
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry
);

   logic [WIDTH:0] chain;

   assign chain[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]       = x[i] ^ y[i] ^ chain[i];
      assign chain[i + 1] = (x[i] & y[i]) | (x[i] & chain[i]) | (y[i] & chain[i]);
   end

   assign carry = chain[WIDTH:1];

endmodule

// File: rtl/seq_mult4_ctrl.sv
// Sequential 4x4 unsigned multiplier: one shared adder, four add/shift iterations,
// a one-cycle done pulse, and a product register held until the next completion.
module seq_mult4_ctrl
   import seq_mult4_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   state_t            state;
   logic [WIDTH-1:0]  m;
   logic [WIDTH-1:0]  q;
   logic [WIDTH-1:0]  acc;
   logic              c;
   logic [CNT_W-1:0]  count;

   logic [WIDTH-1:0]  sum;
   logic [WIDTH-1:0]  carry;
   logic [WIDTH:0]    ca_next;
   logic [PROD_W:0]   shifted;

   adder4 u_adder4 (
      .x     (acc),
      .y     (m),
      .cin   (1'b0),
      .sum   (sum),
      .carry (carry)
   );

   // Add M when the current multiplier LSB is set, then shift {C,A,Q} right with 0 in.
   always_comb begin
      ca_next = q[0] ? {carry[WIDTH-1], sum} : {1'b0, acc};
      shifted = {ca_next, q} >> 1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         m       <= '0;
         q       <= '0;
         acc     <= '0;
         c       <= 1'b0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  m     <= a;
                  q     <= b;
                  acc   <= '0;
                  c     <= 1'b0;
                  count <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               c     <= shifted[PROD_W];
               acc   <= shifted[PROD_W-1:WIDTH];
               q     <= shifted[WIDTH-1:0];
               count <= count + CNT_W'(1);
               if (count == LAST_ITER) begin
                  product <= shifted[PROD_W-1:0];
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == CALC);
   assign done = (state == DONE);

   // The stored C is always zero after a shift and the low carries are internal to the adder.
   logic unused_bits;
   assign unused_bits = ^{carry[WIDTH-2:0], c};

endmodule

// File: tb/tb_seq_mult4_ctrl.sv
// Randomized self-checking bench for seq_mult4_ctrl against an arithmetic reference model.
module tb_seq_mult4_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int checks = 0;
   int fails  = 0;
   logic [7:0] model_prod;

   seq_mult4_ctrl dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Runs one operation with start pulsed for one cycle; a/b are scrambled after acceptance.
   task automatic do_op(input logic [3:0] x, input logic [3:0] y,
                        output logic [7:0] prod_at_done, output logic [7:0] prod_before,
                        output int busy_n, output int done_n, output int done_edge);
      @(negedge clock);
      a = x; b = y; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      a = 4'($urandom); b = 4'($urandom);
      busy_n = busy ? 1 : 0;
      done_n = done ? 1 : 0;
      done_edge = -1;
      prod_at_done = 8'hxx;
      prod_before = product;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clock); #1;
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            done_edge = k;
            prod_at_done = product;
         end
         if (k == 3) prod_before = product;
      end
   endtask

   task automatic test_reset();
      start = 1'b0; a = '0; b = '0;
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
         fails++;
         $display("FAIL reset_async: got busy=%b done=%b product=%h required 0 0 00", busy, done, product);
      end
      repeat (2) @(posedge clock);
      @(negedge clock); reset = 1'b0;
      repeat (3) @(posedge clock); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
         fails++;
         $display("FAIL reset_idle: got busy=%b done=%b product=%h required 0 0 00", busy, done, product);
      end
      model_prod = 8'h00;
   endtask

   task automatic test_directed();
      logic [3:0] xs[3] = '{4'hF, 4'h3, 4'h7};
      logic [3:0] ys[3] = '{4'hF, 4'h5, 4'h0};
      logic [7:0] pd, pb;
      int bn, dn, de;
      for (int i = 0; i < 3; i++) begin
         do_op(xs[i], ys[i], pd, pb, bn, dn, de);
         checks++;
         if (pd !== 8'(xs[i] * ys[i])) begin
            fails++;
            $display("FAIL directed_product[%0d]: got %h required %h", i, pd, 8'(xs[i] * ys[i]));
         end
         checks++;
         if (bn != 4 || dn != 1 || de != 4) begin
            fails++;
            $display("FAIL directed_timing[%0d]: got busy_cycles=%0d done_cycles=%0d done_edge=%0d required 4 1 4", i, bn, dn, de);
         end
         checks++;
         if (pb !== model_prod) begin
            fails++;
            $display("FAIL directed_hold[%0d]: got %h required %h", i, pb, model_prod);
         end
         model_prod = 8'(xs[i] * ys[i]);
      end
   endtask

   task automatic test_back_to_back();
      int done_edges[$];
      int bad_prod = 0;
      @(negedge clock);
      a = 4'd2; b = 4'd9; start = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock); #1;
         if (done) begin
            done_edges.push_back(k);
            if (product !== 8'h12) bad_prod++;
         end
      end
      @(negedge clock); start = 1'b0;
      repeat (8) @(posedge clock);
      checks++;
      if (done_edges.size() != 3 || done_edges[0] != 4 || done_edges[1] != 10 || done_edges[2] != 16) begin
         fails++;
         $display("FAIL back_to_back_period: got %0d done pulses first at edge %0d required 3 pulses at edges 4,10,16",
                  done_edges.size(), (done_edges.size() > 0) ? done_edges[0] : -1);
      end
      checks++;
      if (bad_prod != 0) begin
         fails++;
         $display("FAIL back_to_back_product: got %0d wrong products required 0 (each 12)", bad_prod);
      end
      model_prod = 8'h12;
   endtask

   task automatic test_ignore_start();
      int extra_busy = 0;
      int done_n = 0;
      @(negedge clock);
      a = 4'd6; b = 4'd7; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      a = 4'd15; b = 4'd13; start = 1'b1;
      @(negedge clock);
      start = 1'b0; a = 4'd1; b = 4'd1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clock); #1;
         if (done) done_n++;
         if (k >= 5 && busy) extra_busy++;
      end
      checks++;
      if (product !== 8'h2A) begin
         fails++;
         $display("FAIL ignore_start_product: got %h required 2a", product);
      end
      checks++;
      if (done_n != 1 || extra_busy != 0) begin
         fails++;
         $display("FAIL ignore_start_launch: got done_pulses=%0d late_busy=%0d required 1 0", done_n, extra_busy);
      end
      model_prod = 8'h2A;
   endtask

   task automatic test_reset_mid();
      logic [7:0] pd, pb;
      int bn, dn, de;
      int done_seen = 0;
      @(negedge clock);
      a = 4'hF; b = 4'hF; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid_immediate: got busy=%b done=%b product=%h required 0 0 00", busy, done, product);
      end
      @(negedge clock); reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clock); #1;
         if (done || busy) done_seen++;
      end
      checks++;
      if (done_seen != 0 || product !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid_abort: got activity=%0d product=%h required 0 00", done_seen, product);
      end
      model_prod = 8'h00;
      do_op(4'd1, 4'd1, pd, pb, bn, dn, de);
      checks++;
      if (pd !== 8'h01 || de != 4) begin
         fails++;
         $display("FAIL reset_mid_fresh: got product=%h done_edge=%0d required 01 4", pd, de);
      end
      model_prod = 8'h01;
   endtask

   task automatic test_random();
      logic [7:0] pd, pb;
      int bn, dn, de;
      logic [3:0] x, y;
      for (int i = 0; i < 20; i++) begin
         x = 4'($urandom); y = 4'($urandom);
         do_op(x, y, pd, pb, bn, dn, de);
         checks++;
         if (pd !== 8'(x * y) || pb !== model_prod || bn != 4 || de != 4) begin
            fails++;
            $display("FAIL random[%0d] %0d*%0d: got product=%h held=%h busy=%0d done_edge=%0d required %h %h 4 4",
                     i, x, y, pd, pb, bn, de, 8'(x * y), model_prod);
         end
         model_prod = 8'(x * y);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] pd, pb;
      int bn, dn, de;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            do_op(4'(x), 4'(y), pd, pb, bn, dn, de);
            checks++;
            if (pd !== 8'(x * y) || dn != 1) begin
               fails++;
               $display("FAIL sweep %0d*%0d: got product=%h done_cycles=%0d required %h 1", x, y, pd, dn, 8'(x * y));
            end
            model_prod = 8'(x * y);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      test_random();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
